// File: rtl/lsu_ctrl_if.sv
// Data-bus port of the load/store sequencer: request/grant for the address phase,
// rvalid for returning load data.
interface lsu_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_strb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_strb,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_strb,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer for the 3-stage RV32I core: one bus transaction per access, stall until done.
// Optional MISALIGN_TRAP_EN: misaligned word/half accesses skip the bus and pulse misalign.
//
// state | meaning
// IDLE  | waiting for a load/store from EX; stall follows the request combinationally
// REQ   | mem_req asserted, bus outputs frozen until mem_gnt
// WAIT  | load granted, waiting for mem_rvalid
// DONE  | one-cycle completion: ld_done / st_done / bus_err / misalign
module lsu_ctrl #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [2:0]  ld_type,
    input  logic [2:0]  st_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata_in,
    output logic        stall,
    output logic        ld_done,
    output logic        st_done,
    output logic [31:0] ld_data,
    output logic        bus_err,
    output logic        misalign,
    lsu_ctrl_if.master  mem
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic            TO_EN   = (TIMEOUT > 0);
    localparam logic [TO_W-1:0] TO_LOAD = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q;
    logic            we_q, err_q, mis_q;
    logic [2:0]      kind_q;
    logic [31:0]     addr_q, wdata_q;
    logic [3:0]      strb_q;

    logic            op, is_load, mis_now, expired, timeout_hit;
    logic [2:0]      kind_in;
    logic [31:0]     wdata_rep;
    logic [3:0]      strb_in;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [31:0]     rd_ext;

    // A load wins when decode presents both types at once
    assign op      = ex_valid & ((ld_type != 3'd0) | (st_type != 3'd0));
    assign is_load = (ld_type != 3'd0);
    assign kind_in = is_load ? ld_type : st_type;

    always_comb begin
        wdata_rep = wdata_in;
        strb_in   = 4'b1111;
        if (!is_load) begin
            case (st_type)
                3'd2: begin
                    wdata_rep = {2{wdata_in[15:0]}};
                    strb_in   = addr[1] ? 4'b1100 : 4'b0011;
                end
                3'd3: begin
                    wdata_rep = {4{wdata_in[7:0]}};
                    strb_in   = 4'b0001 << addr[1:0];
                end
                default: ;
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign mis_now = ((kind_in == 3'd1) && (addr[1:0] != 2'b00)) ||
                     (((kind_in == 3'd2) || (is_load && (kind_in == 3'd4))) && addr[0]);
`else
    assign mis_now = 1'b0;
`endif

    // Timer loads TIMEOUT-1 on entry to REQ/WAIT; terminal count means TIMEOUT cycles spent there
    assign expired = TO_EN && (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                stall = op;
                if (op) state_d = mis_now ? DONE : REQ;
            end
            REQ: begin
                stall = 1'b1;
                if (mem.mem_gnt) begin
                    state_d = we_q ? DONE : WAIT;
                end else if (expired) begin
                    state_d     = DONE;
                    timeout_hit = 1'b1;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (mem.mem_rvalid) begin
                    state_d = DONE;
                end else if (expired) begin
                    state_d     = DONE;
                    timeout_hit = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_byte = mem.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        rd_half = addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (kind_q)
            3'd2:    rd_ext = {{16{rd_half[15]}}, rd_half};
            3'd3:    rd_ext = {{24{rd_byte[7]}}, rd_byte};
            3'd4:    rd_ext = {16'h0000, rd_half};
            3'd5:    rd_ext = {24'h000000, rd_byte};
            default: rd_ext = mem.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            kind_q  <= 3'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            strb_q  <= 4'h0;
            ld_data <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (op) begin
                        we_q    <= !is_load;
                        kind_q  <= kind_in;
                        addr_q  <= addr;
                        wdata_q <= wdata_rep;
                        strb_q  <= strb_in;
                        err_q   <= 1'b0;
                        mis_q   <= mis_now;
                        cnt_q   <= TO_LOAD;
                    end
                end
                REQ: begin
                    if (mem.mem_gnt)        cnt_q <= TO_LOAD;
                    else if (cnt_q != '0)   cnt_q <= cnt_q - TO_W'(1);
                    err_q <= timeout_hit;
                end
                WAIT: begin
                    if (mem.mem_rvalid)     ld_data <= rd_ext;
                    else if (cnt_q != '0)   cnt_q <= cnt_q - TO_W'(1);
                    err_q <= timeout_hit;
                end
                default: ;
            endcase
        end
    end

    assign mem.mem_req   = (state_q == REQ);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = {addr_q[31:2], 2'b00};
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_strb  = strb_q;

    assign ld_done  = (state_q == DONE) && !we_q && !err_q && !mis_q;
    assign st_done  = (state_q == DONE) &&  we_q && !err_q && !mis_q;
    assign bus_err  = (state_q == DONE) && err_q;
    assign misalign = (state_q == DONE) && mis_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: completion pulses are checked against a queue of expected events.
module tb_lsu_ctrl;
    localparam logic [3:0] K_LD  = 4'b1000;
    localparam logic [3:0] K_ST  = 4'b0100;
    localparam logic [3:0] K_ERR = 4'b0010;
    localparam logic [3:0] K_MIS = 4'b0001;

    typedef struct packed {
        logic [3:0]  kind;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic [2:0]  ld_type = 3'd0;
    logic [2:0]  st_type = 3'd0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata_in = 32'h0;
    logic        stall, ld_done, st_done, bus_err, misalign;
    logic [31:0] ld_data;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sbq[$];
    exp_t e_pop;
    logic [3:0] pulses;

    lsu_ctrl_if bus ();

    lsu_ctrl #(.TO_W(8), .TIMEOUT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .ex_valid (ex_valid),
        .ld_type  (ld_type),
        .st_type  (st_type),
        .addr     (addr),
        .wdata_in (wdata_in),
        .stall    (stall),
        .ld_done  (ld_done),
        .st_done  (st_done),
        .ld_data  (ld_data),
        .bus_err  (bus_err),
        .misalign (misalign),
        .mem      (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic [3:0] k, input logic [31:0] d);
        exp_t e;
        e.kind = k;
        e.data = d;
        sbq.push_back(e);
    endtask

    // Presents one access for a single cycle; returns one cycle later with inputs cleared
    task automatic issue(input logic [2:0] lt, input logic [2:0] st, input logic [31:0] a, input logic [31:0] w);
        ex_valid = 1'b1;
        ld_type  = lt;
        st_type  = st;
        addr     = a;
        wdata_in = w;
        #1;
        chk("stall_accept", stall, 1);
        tick();
        ex_valid = 1'b0;
        ld_type  = 3'd0;
        st_type  = 3'd0;
    endtask

    task automatic do_store(input logic [2:0] st, input logic [31:0] a, input logic [31:0] w,
                            input logic [3:0] e_strb, input logic [31:0] e_wdata);
        expect_ev(K_ST, 32'h0);
        issue(3'd0, st, a, w);
        chk("st_req", bus.mem_req, 1);
        chk("st_we", bus.mem_we, 1);
        chk("st_addr", bus.mem_addr, {a[31:2], 2'b00});
        chk("st_strb", bus.mem_strb, e_strb);
        chk("st_wdata", bus.mem_wdata, e_wdata);
        chk("st_stall_req", stall, 1);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        chk("st_done_stall", stall, 0);
        chk("st_done_req", bus.mem_req, 0);
        tick();
    endtask

    task automatic do_load(input logic [2:0] lt, input logic [2:0] st, input logic [31:0] a,
                           input logic [31:0] rd, input int gdly, input logic [31:0] e_data);
        expect_ev(K_LD, e_data);
        issue(lt, st, a, 32'h5555_AAAA);
        for (int i = 0; i < gdly; i++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'hFFFF_FFFF;
            chk("ld_req_hold", bus.mem_req, 1);
            chk("ld_addr_hold", bus.mem_addr, {a[31:2], 2'b00});
            tick();
        end
        bus.mem_rvalid = 1'b0;
        chk("ld_req", bus.mem_req, 1);
        chk("ld_we", bus.mem_we, 0);
        chk("ld_strb", bus.mem_strb, 4'b1111);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        chk("ld_wait_req", bus.mem_req, 0);
        chk("ld_wait_stall", stall, 1);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rd;
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0BAD_F00D;
        chk("ld_done_stall", stall, 0);
        chk("ld_data_done", ld_data, e_data);
        tick();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            pulses = {ld_done, st_done, bus_err, misalign};
            if (pulses != 4'b0000) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_pulse", {28'h0, pulses}, 32'h0);
                end else begin
                    e_pop = sbq.pop_front();
                    chk("done_kind", {28'h0, pulses}, {28'h0, e_pop.kind});
                    if (e_pop.kind == K_LD) chk("sb_ld_data", ld_data, e_pop.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench did not finish");
    end

    initial begin
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        tick();
        tick();
        chk("rst_stall", stall, 0);
        chk("rst_pulses", {ld_done, st_done, bus_err, misalign}, 0);
        chk("rst_ld_data", ld_data, 0);
        chk("rst_req", bus.mem_req, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_strb", bus.mem_strb, 0);
        rst = 1'b0;
        tick();

        do_store(3'd1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        do_store(3'd3, 32'h0000_0103, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
        do_store(3'd2, 32'h0000_0102, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
        do_store(3'd3, 32'h0000_0100, 32'h0000_0012, 4'b0001, 32'h1212_1212);

        do_load(3'd3, 3'd0, 32'h0000_0102, 32'h0080_0000, 0, 32'hFFFF_FF80);
        do_load(3'd5, 3'd0, 32'h0000_0102, 32'h0080_0000, 0, 32'h0000_0080);
        do_load(3'd2, 3'd0, 32'h0000_0102, 32'h8001_0000, 2, 32'hFFFF_8001);
        do_load(3'd4, 3'd0, 32'h0000_0100, 32'h1234_F00D, 0, 32'h0000_F00D);
        do_load(3'd3, 3'd0, 32'h0000_0101, 32'h0000_7F00, 1, 32'h0000_007F);
        do_load(3'd1, 3'd0, 32'h0000_0104, 32'hCAFE_BABE, 0, 32'hCAFE_BABE);
        do_load(3'd1, 3'd1, 32'h0000_0108, 32'h1357_9BDF, 0, 32'h1357_9BDF);

        // Bus never grants: four REQ cycles then an error completion
        expect_ev(K_ERR, 32'h0);
        issue(3'd1, 3'd0, 32'h0000_0200, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("to_req", bus.mem_req, 1);
            chk("to_stall", stall, 1);
            tick();
        end
        chk("to_done_stall", stall, 0);
        chk("to_done_req", bus.mem_req, 0);
        chk("to_bus_err", bus_err, 1);
        chk("to_ld_done", ld_done, 0);
        chk("to_ld_data", ld_data, 32'h1357_9BDF);
        tick();

`ifdef MISALIGN_TRAP_EN
        expect_ev(K_MIS, 32'h0);
        issue(3'd1, 3'd0, 32'h0000_0101, 32'h0);
        chk("mis_lw_req", bus.mem_req, 0);
        chk("mis_lw_stall", stall, 0);
        tick();
        chk("mis_lw_idle_req", bus.mem_req, 0);
        expect_ev(K_MIS, 32'h0);
        issue(3'd0, 3'd2, 32'h0000_0101, 32'h0000_BEEF);
        chk("mis_sh_req", bus.mem_req, 0);
        tick();
`else
        do_load(3'd1, 3'd0, 32'h0000_0101, 32'h89AB_CDEF, 0, 32'h89AB_CDEF);
        do_load(3'd2, 3'd0, 32'h0000_0101, 32'hAAAA_5555, 0, 32'h0000_5555);
`endif

        // Reset while a load waits for data
        issue(3'd1, 3'd0, 32'h0000_010C, 32'h0);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        chk("rw_stall_wait", stall, 1);
        rst = 1'b1;
        #1;
        chk("rw_stall", stall, 0);
        chk("rw_req", bus.mem_req, 0);
        chk("rw_ld_data", ld_data, 0);
        chk("rw_addr", bus.mem_addr, 0);
        chk("rw_strb", bus.mem_strb, 0);
        tick();
        rst = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFF_FFFF;
        tick();
        bus.mem_rvalid = 1'b0;
        chk("rw_rvalid_idle", ld_data, 0);
        chk("rw_idle_stall", stall, 0);

        // Reset while requesting drops mem_req without waiting for a clock
        issue(3'd0, 3'd1, 32'h0000_0300, 32'h1111_2222);
        chk("rr_req_before", bus.mem_req, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rr_req_async", bus.mem_req, 0);
        tick();
        rst = 1'b0;
        tick();

        do_store(3'd1, 32'h0000_0104, 32'h0102_0304, 4'b1111, 32'h0102_0304);
        tick();
        chk("sb_empty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
